// File: rtl/reset_seq_pkg.sv
// reset_seq_pkg: shared state encoding, sizing helpers and parameter legality checks
package reset_seq_pkg;
    typedef enum logic [2:0] {HOLD, DELAY, WAIT_ACK, DONE, FAULT} state_t;
    function automatic int cnt_width(input int h, input int s, input int a);
        int m;
        m = (h > s) ? h : s;
        m = (a > m) ? a : m;
        return $clog2(m + 1);
    endfunction
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
    function automatic bit params_ok(input int n, input int h, input int s, input int a);
        return (n >= 1) && (n <= 16) && (h >= 1) && (s >= 1) && (a >= 0);
    endfunction
endpackage

// File: rtl/rst_seq_counter.sv
// rst_seq_counter: clearable saturating up-counter flagging when the next increment hits the target
module rst_seq_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_clr,
    input  logic         i_inc,
    input  logic [W-1:0] i_target,
    output logic         o_hit
);
    logic [W-1:0] r_count;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_count <= '0;
        else if (i_clr) r_count <= '0;
        else if (i_inc && r_count != '1) r_count <= r_count + 1'b1;
    end
    // widened compare so a target of all ones never aliases with wrap-around
    assign o_hit = ({1'b0, r_count} + 1'b1) == {1'b0, i_target};
endmodule

// File: rtl/reset_sequencer.sv
// reset_sequencer: releases reset domains in order with per-stage delay, ack handshake and timeout supervision
module reset_sequencer
    import reset_seq_pkg::*;
#(
    parameter int   NUM_STAGES  = 4,
    parameter int   HOLD_CYCLES = 8,
    parameter int   STAGE_DELAY = 16,
    parameter int   ACK_TIMEOUT = 255,
    parameter logic REQ_POL     = 1'b0
) (
    input  logic                                 clk,
    input  logic                                 rst_i,
    input  logic                                 rst_req_i,
    input  logic [NUM_STAGES-1:0]                stage_ack_i,
    output logic [NUM_STAGES-1:0]                stage_rst_o,
    output logic                                 done_o,
    output logic                                 timeout_o,
    output logic [idx_width(NUM_STAGES)-1:0]     fault_stage_o
);
    localparam int CW = cnt_width(HOLD_CYCLES, STAGE_DELAY, ACK_TIMEOUT);
    localparam int FW = idx_width(NUM_STAGES);
    if (!params_ok(NUM_STAGES, HOLD_CYCLES, STAGE_DELAY, ACK_TIMEOUT)) begin : g_bad_params
        $error("reset_sequencer: illegal parameter combination");
    end
    state_t                  r_state, w_state_nx;
    logic [FW-1:0]           r_idx, w_idx_nx, r_fault_stage, w_fs_nx;
    logic [NUM_STAGES-1:0]   r_stage_rst, w_rst_nx;
    logic                    r_done, w_done_nx, r_timeout, w_to_nx;
    logic                    w_clr, w_inc, w_hit;
    logic [CW-1:0]           w_target;
    assign w_target = (r_state == HOLD)  ? CW'(HOLD_CYCLES) :
                      (r_state == DELAY) ? CW'(STAGE_DELAY) : CW'(ACK_TIMEOUT);
    rst_seq_counter #(.W(CW)) u_cnt (
        .clk      (clk),
        .rst_n    (rst_i),
        .i_clr    (w_clr),
        .i_inc    (w_inc),
        .i_target (w_target),
        .o_hit    (w_hit)
    );
    always_comb begin
        w_state_nx = r_state;
        w_idx_nx   = r_idx;
        w_rst_nx   = r_stage_rst;
        w_done_nx  = r_done;
        w_to_nx    = r_timeout;
        w_fs_nx    = r_fault_stage;
        w_clr      = 1'b0;
        w_inc      = 1'b0;
        // a request overrides every state, including the terminal ones
        if (rst_req_i == REQ_POL) begin
            w_state_nx = HOLD;
            w_idx_nx   = '0;
            w_rst_nx   = '1;
            w_done_nx  = 1'b0;
            w_to_nx    = 1'b0;
            w_fs_nx    = '0;
            w_clr      = 1'b1;
        end else begin
            case (r_state)
                HOLD: begin
                    w_state_nx = w_hit ? DELAY : HOLD;
                    w_clr      = w_hit;
                    w_inc      = !w_hit;
                end
                DELAY: begin
                    if (w_hit) begin
                        w_rst_nx[r_idx] = 1'b0;
                        w_state_nx      = WAIT_ACK;
                        w_clr           = 1'b1;
                    end else w_inc = 1'b1;
                end
                WAIT_ACK: begin
                    if (stage_ack_i[r_idx]) begin
                        w_clr = 1'b1;
                        if (r_idx == FW'(NUM_STAGES - 1)) begin
                            w_state_nx = DONE;
                            w_done_nx  = 1'b1;
                        end else begin
                            w_state_nx = DELAY;
                            w_idx_nx   = r_idx + 1'b1;
                        end
                    end else if (ACK_TIMEOUT != 0 && w_hit) begin
                        w_state_nx = FAULT;
                        w_to_nx    = 1'b1;
                        w_fs_nx    = r_idx;
                        w_rst_nx   = '1;
                        w_done_nx  = 1'b0;
                        w_clr      = 1'b1;
                    end else w_inc = 1'b1;
                end
                default: ;
            endcase
        end
    end
    always_ff @(posedge clk or negedge rst_i) begin
        if (!rst_i) begin
            r_state       <= HOLD;
            r_idx         <= '0;
            r_stage_rst   <= '1;
            r_done        <= 1'b0;
            r_timeout     <= 1'b0;
            r_fault_stage <= '0;
        end else begin
            r_state       <= w_state_nx;
            r_idx         <= w_idx_nx;
            r_stage_rst   <= w_rst_nx;
            r_done        <= w_done_nx;
            r_timeout     <= w_to_nx;
            r_fault_stage <= w_fs_nx;
        end
    end
    assign stage_rst_o   = r_stage_rst;
    assign done_o        = r_done;
    assign timeout_o     = r_timeout;
    assign fault_stage_o = r_fault_stage;
endmodule

// File: tb/tb_reset_sequencer.sv
// tb_reset_sequencer: directed stimulus with a change-driven scoreboard of expected output events and edge numbers
module tb_reset_sequencer;
    logic       clk = 1'b0;
    logic       rst_i = 1'b1;
    logic       rst_req_i = 1'b1;
    logic [3:0] stage_ack_i = 4'hf;
    logic [3:0] stage_rst_o;
    logic       done_o, timeout_o;
    logic [1:0] fault_stage_o;
    logic       probe = 1'b0;
    int         cyc = 0, checks = 0, failures = 0;
    typedef struct {
        int         cyc;
        logic [3:0] rst;
        logic       done;
        logic       to;
        logic [1:0] fs;
        string      name;
    } exp_t;
    exp_t exp_q[$];
    reset_sequencer #(
        .NUM_STAGES(4), .HOLD_CYCLES(8), .STAGE_DELAY(16), .ACK_TIMEOUT(255), .REQ_POL(1'b0)
    ) dut (
        .clk           (clk),
        .rst_i         (rst_i),
        .rst_req_i     (rst_req_i),
        .stage_ack_i   (stage_ack_i),
        .stage_rst_o   (stage_rst_o),
        .done_o        (done_o),
        .timeout_o     (timeout_o),
        .fault_stage_o (fault_stage_o)
    );
    initial begin
        #20;
        forever #5 clk = ~clk;
    end
    always @(posedge clk) cyc++;
    task automatic push(input int c, input logic [3:0] r, input logic d, input logic t,
                        input logic [1:0] f, input string n);
        exp_t e;
        e.cyc = c; e.rst = r; e.done = d; e.to = t; e.fs = f; e.name = n;
        exp_q.push_back(e);
    endtask
    task automatic seq(input int b, input string tag);
        push(b + 24, 4'b1110, 1'b0, 1'b0, 2'd0, {tag, "_s0"});
        push(b + 41, 4'b1100, 1'b0, 1'b0, 2'd0, {tag, "_s1"});
        push(b + 58, 4'b1000, 1'b0, 1'b0, 2'd0, {tag, "_s2"});
        push(b + 75, 4'b0000, 1'b0, 1'b0, 2'd0, {tag, "_s3"});
        push(b + 76, 4'b0000, 1'b1, 1'b0, 2'd0, {tag, "_done"});
    endtask
    task automatic wait_to(input int c);
        while (cyc < c) @(negedge clk);
    endtask
    task automatic pulse_req(input string n);
        push(cyc + 1, 4'b1111, 1'b0, 1'b0, 2'd0, n);
        rst_req_i = 1'b0;
        @(negedge clk);
        rst_req_i = 1'b1;
    endtask
    initial begin
        exp_t e;
        #2;
        forever begin
            @(stage_rst_o or done_o or timeout_o or fault_stage_o or probe);
            #1;
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_change cyc=%0d got rst=%b done=%b to=%b fs=%0d",
                         cyc, stage_rst_o, done_o, timeout_o, fault_stage_o);
            end else begin
                e = exp_q.pop_front();
                if (cyc !== e.cyc || stage_rst_o !== e.rst || done_o !== e.done ||
                    timeout_o !== e.to || fault_stage_o !== e.fs) begin
                    failures++;
                    $display("FAIL %s got cyc=%0d rst=%b done=%b to=%b fs=%0d exp cyc=%0d rst=%b done=%b to=%b fs=%0d",
                             e.name, cyc, stage_rst_o, done_o, timeout_o, fault_stage_o,
                             e.cyc, e.rst, e.done, e.to, e.fs);
                end
            end
        end
    end
    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d pending=%0d", cyc, exp_q.size());
        $fatal(1, "watchdog expired");
    end
    initial begin
        int   b;
        exp_t e;
        #5;
        push(0, 4'b1111, 1'b0, 1'b0, 2'd0, "por");
        rst_i = 1'b0;
        #5;
        if (exp_q.size() != 0) probe = ~probe;
        repeat (5) @(negedge clk);
        b = cyc;
        seq(b, "por");
        rst_i = 1'b1;
        wait_to(b + 80);
        pulse_req("req_done");
        b = cyc;
        stage_ack_i = 4'b1101;
        push(b + 24, 4'b1110, 1'b0, 1'b0, 2'd0, "slow_s0");
        push(b + 41, 4'b1100, 1'b0, 1'b0, 2'd0, "slow_s1");
        wait_to(b + 51);
        stage_ack_i[1] = 1'b1;
        push(b + 68, 4'b1000, 1'b0, 1'b0, 2'd0, "slow_s2");
        push(b + 85, 4'b0000, 1'b0, 1'b0, 2'd0, "slow_s3");
        push(b + 86, 4'b0000, 1'b1, 1'b0, 2'd0, "slow_done");
        wait_to(b + 95);
        pulse_req("req_done2");
        b = cyc;
        stage_ack_i = 4'b1011;
        push(b + 24, 4'b1110, 1'b0, 1'b0, 2'd0, "to_s0");
        push(b + 41, 4'b1100, 1'b0, 1'b0, 2'd0, "to_s1");
        push(b + 58, 4'b1000, 1'b0, 1'b0, 2'd0, "to_s2");
        push(b + 313, 4'b1111, 1'b0, 1'b1, 2'd2, "timeout");
        wait_to(b + 340);
        pulse_req("req_fault");
        b = cyc;
        stage_ack_i = 4'hf;
        push(b + 24, 4'b1110, 1'b0, 1'b0, 2'd0, "mid_s0");
        push(b + 41, 4'b1100, 1'b0, 1'b0, 2'd0, "mid_s1");
        wait_to(b + 42);
        rst_req_i = 1'b0;
        push(b + 43, 4'b1111, 1'b0, 1'b0, 2'd0, "mid_req");
        @(negedge clk);
        rst_req_i = 1'b1;
        b = cyc;
        seq(b, "restart");
        wait_to(b + 80);
        pulse_req("req_done3");
        b = cyc;
        push(b + 24, 4'b1110, 1'b0, 1'b0, 2'd0, "async_s0");
        wait_to(b + 30);
        #2;
        push(cyc, 4'b1111, 1'b0, 1'b0, 2'd0, "async_rst");
        rst_i = 1'b0;
        repeat (3) @(negedge clk);
        rst_i = 1'b1;
        b = cyc;
        seq(b, "after_async");
        wait_to(b + 80);
        #1;
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            checks++;
            failures++;
            $display("FAIL %s missing event exp cyc=%0d rst=%b done=%b to=%b fs=%0d",
                     e.name, e.cyc, e.rst, e.done, e.to, e.fs);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
